exec_controller: RTL and testbench

EXEC_CONTROLLER -- requirements
Module: exec_controller

---
 rtl/exec_controller.sv | 120 ++++++++++++
 tb/tb_exec_controller.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/exec_controller.sv
// Multi-cycle execute controller: sequences operand reads, ALU execute and write-back for 16-bit instructions.
// Optional flag register enabled by defining EXEC_FLAGS_EN; otherwise flags read as zero.
`timescale 1ns/1ps
module exec_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [2:0]  pa,
  output logic        rdr,
  output logic [2:0]  wp,
  output logic        wrr,
  output logic [2:0]  fsel,
  output logic        ld_x,
  output logic        ld_y,
  output logic        ld_z,
  input  logic        c_in,
  input  logic        v_in,
  input  logic        s_in,
  input  logic        z_in,
  output logic [3:0]  flags,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB} state_t;

  localparam logic [2:0] OP_NOP = 3'b101;

  state_t      state_q, state_d;
  logic [15:4] ir_q, ir_d;
  logic [2:0]  op_q;
  logic        unused_instr;

  // The low nibble of the instruction carries no information for this controller.
  assign unused_instr = ^instr[3:0];
  assign op_q = ir_q[15:13];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    instr_ready = 1'b0;
    pa          = 3'b000;
    rdr         = 1'b0;
    wp          = 3'b000;
    wrr         = 1'b0;
    fsel        = op_q;
    ld_x        = 1'b0;
    ld_y        = 1'b0;
    ld_z        = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        fsel        = 3'b000;
        if (instr_valid) begin
          ir_d    = instr[15:4];
          state_d = (instr[15:13] == OP_NOP) ? WB : RD_A;
        end
      end
      RD_A: begin
        pa      = ir_q[9:7];
        rdr     = 1'b1;
        ld_x    = 1'b1;
        // Ops 000-011 are binary and need a second operand; 100/110/111 are unary.
        state_d = op_q[2] ? EXEC : RD_B;
      end
      RD_B: begin
        pa      = ir_q[6:4];
        rdr     = 1'b1;
        ld_y    = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        ld_z    = 1'b1;
        state_d = WB;
      end
      WB: begin
        wp      = ir_q[12:10];
        wrr     = (op_q != OP_NOP);
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        fsel    = 3'b000;
        state_d = IDLE;
      end
    endcase
  end

`ifdef EXEC_FLAGS_EN
  logic [3:0] flags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (state_q == EXEC) begin
      flags_q <= {c_in, v_in, s_in, z_in};
    end
  end

  assign flags = flags_q;
`else
  logic unused_alu_flags;

  assign unused_alu_flags = ^{c_in, v_in, s_in, z_in};
  assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_exec_controller.sv
// Directed self-checking bench for exec_controller; expected flag values follow EXEC_FLAGS_EN.
`timescale 1ns/1ps
module tb_exec_controller;

`ifdef EXEC_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  pa;
  logic        rdr;
  logic [2:0]  wp;
  logic        wrr;
  logic [2:0]  fsel;
  logic        ld_x, ld_y, ld_z;
  logic        c_in, v_in, s_in, z_in;
  logic [3:0]  flags;
  logic        done;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] expFlags;

  exec_controller dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pa(pa), .rdr(rdr), .wp(wp), .wrr(wrr),
    .fsel(fsel), .ld_x(ld_x), .ld_y(ld_y), .ld_z(ld_z),
    .c_in(c_in), .v_in(v_in), .s_in(s_in), .z_in(z_in),
    .flags(flags), .done(done)
  );

  always #5 clk = ~clk;

  // Packed view: {ready, pa, rdr, wp, wrr, fsel, ld_x, ld_y, ld_z, done, flags}
  function automatic logic [19:0] ex(input logic rdy, input logic [2:0] a, input logic rd,
                                     input logic [2:0] w, input logic wr, input logic [2:0] f,
                                     input logic lx, input logic ly, input logic lz,
                                     input logic dn);
    ex = {rdy, a, rd, w, wr, f, lx, ly, lz, dn, (FLAGS_ON ? expFlags : 4'b0000)};
  endfunction

  task automatic applyStimulus(input logic r, input logic v, input logic [15:0] in,
                               input logic [3:0] fl);
    rst         = r;
    instr_valid = v;
    instr       = in;
    {c_in, v_in, s_in, z_in} = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [19:0] exp);
    logic [19:0] obs;
    obs = {instr_ready, pa, rdr, wp, wrr, fsel, ld_x, ld_y, ld_z, done, flags};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  initial begin
    expFlags = 4'b0000;
    // Reset wins over a pending handshake.
    applyStimulus(1'b1, 1'b1, 16'h0CA0, 4'b0110);
    tick();
    checkOutput("reset_state", ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    checkOutput("reset_priority", ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // ADD r3 = r1 + r2
    applyStimulus(1'b0, 1'b1, 16'h0CA0, 4'b0110);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 4'b0110);
    checkOutput("add_rd_a", ex(0, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    tick();
    checkOutput("add_rd_b", ex(0, 2, 1, 0, 0, 0, 0, 1, 0, 0));
    tick();
    checkOutput("add_exec", ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tick();
    expFlags = 4'b0110;
    checkOutput("add_wb", ex(0, 0, 0, 3, 1, 0, 0, 0, 0, 1));
    tick();
    checkOutput("add_idle", ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // NEG r5 = -r4, unary path skips RD_B
    applyStimulus(1'b0, 1'b1, 16'h9600, 4'b0011);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 4'b0011);
    checkOutput("neg_rd_a", ex(0, 4, 1, 0, 0, 4, 1, 0, 0, 0));
    tick();
    checkOutput("neg_exec", ex(0, 0, 0, 0, 0, 4, 0, 0, 1, 0));
    tick();
    expFlags = 4'b0011;
    checkOutput("neg_wb", ex(0, 0, 0, 5, 1, 4, 0, 0, 0, 1));
    tick();
    checkOutput("neg_idle", ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // SUB r7 = r6 - r5 with C=1 Z=1
    applyStimulus(1'b0, 1'b1, 16'h3F50, 4'b1001);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 4'b1001);
    checkOutput("sub_rd_a", ex(0, 6, 1, 0, 0, 1, 1, 0, 0, 0));
    tick();
    checkOutput("sub_rd_b", ex(0, 5, 1, 0, 0, 1, 0, 1, 0, 0));
    tick();
    checkOutput("sub_exec", ex(0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    applyStimulus(1'b0, 1'b0, 16'h0000, 4'b1001);
    tick();
    expFlags = 4'b1001;
    checkOutput("sub_wb", ex(0, 0, 0, 7, 1, 1, 0, 0, 0, 1));
    tick();
    checkOutput("sub_idle", ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // NOP: straight to WB, no write, flags untouched even with new ALU flags
    applyStimulus(1'b0, 1'b1, 16'hA000, 4'b1111);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 4'b1111);
    checkOutput("nop_wb", ex(0, 0, 0, 0, 0, 5, 0, 0, 0, 1));
    tick();
    checkOutput("nop_idle", ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset during RD_B abandons the instruction
    applyStimulus(1'b0, 1'b1, 16'h0CA0, 4'b0110);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 4'b0110);
    checkOutput("rst_mid_rd_a", ex(0, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    tick();
    checkOutput("rst_mid_rd_b", ex(0, 2, 1, 0, 0, 0, 0, 1, 0, 0));
    applyStimulus(1'b1, 1'b0, 16'h0000, 4'b0110);
    tick();
    expFlags = 4'b0000;
    checkOutput("rst_mid_idle", ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(1'b0, 1'b0, 16'h0000, 4'b0110);
    tick();
    checkOutput("rst_mid_quiet", ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Back-to-back ADDs with instr_valid held; garbage on instr while busy
    applyStimulus(1'b0, 1'b1, 16'h0CA0, 4'b0101);
    tick();
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 4'b0101);
    checkOutput("b2b1_rd_a", ex(0, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    tick();
    checkOutput("b2b1_rd_b", ex(0, 2, 1, 0, 0, 0, 0, 1, 0, 0));
    tick();
    checkOutput("b2b1_exec", ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tick();
    expFlags = 4'b0101;
    checkOutput("b2b1_wb", ex(0, 0, 0, 3, 1, 0, 0, 0, 0, 1));
    applyStimulus(1'b0, 1'b1, 16'h1110, 4'b1100);
    tick();
    checkOutput("b2b_gap_idle", ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 4'b1100);
    checkOutput("b2b2_rd_a", ex(0, 2, 1, 0, 0, 0, 1, 0, 0, 0));
    tick();
    checkOutput("b2b2_rd_b", ex(0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
    tick();
    checkOutput("b2b2_exec", ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tick();
    expFlags = 4'b1100;
    checkOutput("b2b2_wb", ex(0, 0, 0, 4, 1, 0, 0, 0, 0, 1));
    tick();
    checkOutput("b2b2_idle", ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
